// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // FETCH: request on the bus; WAIT: one request outstanding; HOLD: response parked in skid
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0 -- harmless filler for an empty IF/ID entry
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // word stride between sequential fetches
    localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: valid/ready request, valid-only response.
// Latency: response at least one cycle after request acceptance.
// Backpressure: request side only (imem_req_ready); responses cannot be stalled.
interface fetch_unit_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) ();

    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [PC_W-1:0]  imem_req_addr;
    logic             imem_rsp_valid;
    logic [INS_W-1:0] imem_rsp_data;

    // fetch-unit side
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // memory side
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register for a response that IF/ID cannot take yet.
// Latency: contents visible the cycle after load.
// Backpressure: none internally; caller must not load while full (clear wins over load).
module fetch_skid_buffer #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [INS_W-1:0] in_instr,
    output logic             valid,
    output logic [PC_W-1:0]  pc,
    output logic [INS_W-1:0] instr
);

    // occupancy flag: clear (flush or drain) takes priority over a new capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // payload only moves on capture; stale data behind valid=0 is harmless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            instr <= '0;
        end else if (load && !clear) begin
            pc    <= in_pc;
            instr <= in_instr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one word fetch at a time, fills IF/ID, flushes on redirect.
// Latency: request accepted at N, response at N+R, if_valid at N+R+1 (2 cycles/instr on zero-wait memory).
// Backpressure: stall holds IF/ID; a response landing under stall parks in a skid and blocks new requests.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PcSel,
    input  logic [31:0]         BrPC,
    input  logic                stall,
    fetch_unit_if.master        imem,
    output logic                if_valid,
    output logic [PC_W-1:0]     if_pc,
    output logic [INS_W-1:0]    if_instr
);

    fetch_state_e     state_q;
    fetch_state_e     state_nxt;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  inflight_pc_q;
    logic             discard_q;

    logic             req_hs;
    logic             if_accept;
    logic             load_rsp;
    logic             skid_load;
    logic             skid_to_if;
    logic             skid_clear;
    logic             skid_valid;
    logic [PC_W-1:0]  skid_pc;
    logic [INS_W-1:0] skid_instr;
    logic [PC_W-1:0]  redirect_pc;

    // target is word-aligned and truncated to the PC width
    assign redirect_pc = {BrPC[PC_W-1:2], 2'b00};

    logic unused_brpc;
    assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

    assign req_hs    = imem.imem_req_valid && imem.imem_req_ready;
    // IF/ID can take a new entry when empty or being consumed this cycle
    assign if_accept = !if_valid || !stall;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next state; a redirect never leaves us in HOLD
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            FETCH: begin
                if (req_hs) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (PcSel || discard_q || if_accept) begin
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (PcSel || !stall) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // FSM outputs: bus request and the IF/ID / skid steering strobes
    always_comb begin
        imem.imem_req_valid = (state_q == FETCH) && !reset;
        imem.imem_req_addr  = pc_q;
        load_rsp   = (state_q == WAIT) && imem.imem_rsp_valid && !PcSel && !discard_q && if_accept;
        skid_load  = (state_q == WAIT) && imem.imem_rsp_valid && !PcSel && !discard_q && !if_accept;
        skid_to_if = (state_q == HOLD) && skid_valid && !PcSel && !stall;
        skid_clear = PcSel || skid_to_if;
    end

    // PC: redirect overrides the sequential increment even on a same-cycle handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (PcSel) begin
            pc_q <= redirect_pc;
        end else if (req_hs) begin
            pc_q <= pc_q + PC_W'(PC_INC);
        end
    end

    // remember which address the outstanding response belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_pc_q <= '0;
        end else if (req_hs) begin
            inflight_pc_q <= pc_q;
        end
    end

    // discard marks an outstanding response as wrong-path after a redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            discard_q <= 1'b0;
        end else if (PcSel) begin
            discard_q <= ((state_q == FETCH) && req_hs) ||
                         ((state_q == WAIT) && !imem.imem_rsp_valid);
        end else if ((state_q == WAIT) && imem.imem_rsp_valid) begin
            discard_q <= 1'b0;
        end
    end

    // IF/ID register: flush > fresh response > skid drain > consume; holds under stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= INS_W'(NOP_INSTR);
        end else if (PcSel) begin
            if_valid <= 1'b0;
        end else if (load_rsp) begin
            if_valid <= 1'b1;
            if_pc    <= inflight_pc_q;
            if_instr <= imem.imem_rsp_data;
        end else if (skid_to_if) begin
            if_valid <= 1'b1;
            if_pc    <= skid_pc;
            if_instr <= skid_instr;
        end else if (!stall) begin
            if_valid <= 1'b0;
        end
    end

    fetch_skid_buffer #(
        .PC_W  (PC_W),
        .INS_W (INS_W)
    ) u_skid (
        .clk      (clk),
        .rst      (reset),
        .load     (skid_load),
        .clear    (skid_clear),
        .in_pc    (inflight_pc_q),
        .in_instr (imem.imem_rsp_data),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

endmodule
